// File: rtl/sid_pkg.sv
// Shared types, register offsets and address-map helpers for the SID register bank.
package sid_pkg;

  typedef struct packed {
    logic [15:0] freq;
    logic [11:0] pw;
    logic [7:0]  control;  // noise, pulse, saw, tri, test, ring, sync, gate
    logic [3:0]  atk;
    logic [3:0]  dcy;
    logic [3:0]  stn;
    logic [3:0]  rls;
  } voice_cfg_t;

  typedef struct packed {
    logic [10:0] fc;
    logic [3:0]  res;
    logic [3:0]  filt;
    logic        off3;
    logic        hp;
    logic        bp;
    logic        lp;
    logic [3:0]  vol;
  } filter_cfg_t;

  localparam int unsigned VOICE_REGS = 7;

  localparam int unsigned OFF_FREQ_LO = 0;
  localparam int unsigned OFF_FREQ_HI = 1;
  localparam int unsigned OFF_PW_LO   = 2;
  localparam int unsigned OFF_PW_HI   = 3;
  localparam int unsigned OFF_CTRL    = 4;
  localparam int unsigned OFF_AD      = 5;
  localparam int unsigned OFF_SR      = 6;

  localparam int unsigned OFF_FC_LO    = 0;
  localparam int unsigned OFF_FC_HI    = 1;
  localparam int unsigned OFF_RES_FILT = 2;
  localparam int unsigned OFF_MODE_VOL = 3;
  localparam int unsigned OFF_POTX     = 4;
  localparam int unsigned OFF_POTY     = 5;
  localparam int unsigned OFF_OSC3     = 6;
  localparam int unsigned OFF_ENV3     = 7;

  localparam int unsigned FILTER_REGS  = 8;
  localparam int unsigned CTRL_GATE    = 0;

  function automatic int unsigned fb_base(input int unsigned num_voices);
    return VOICE_REGS * num_voices;
  endfunction

endpackage

// File: rtl/sid_bus_latch.sv
// Data-bus latch with decay: holds the last bus value until enough chip-clock ticks pass.
module sid_bus_latch #(
  parameter int unsigned DECAY_TICKS = 2048
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] latch_q
);

  localparam int unsigned CNT_W = $clog2(DECAY_TICKS + 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      // A reload beats a decay tick arriving in the same cycle.
      latch_q <= load_data;
      cnt_q   <= CNT_W'(DECAY_TICKS);
    end else if (clk_en && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) latch_q <= '0;
    end
  end

endmodule

// File: rtl/sid_regbank.sv
// SID-style register bank: address decode, voice/filter config registers, read mux, gate edges.
module sid_regbank
  import sid_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 3,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DECAY_TICKS = 2048
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_en,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [7:0]                     data_in,
  input  logic                           n_cs,
  input  logic                           rw,
  output logic [7:0]                     data_out,
  output logic                           data_oe,
  input  logic [7:0]                     pot_x,
  input  logic [7:0]                     pot_y,
  input  logic [NUM_VOICES-1:0][7:0]     osc_msb,
  input  logic [NUM_VOICES-1:0][7:0]     env_lvl,
  output voice_cfg_t [NUM_VOICES-1:0]    voice_cfg,
  output filter_cfg_t                    filt_cfg,
  output logic [NUM_VOICES-1:0]          gate_on,
  output logic [NUM_VOICES-1:0]          gate_off
);

  localparam int unsigned FB = fb_base(NUM_VOICES);

  if (NUM_VOICES < 1 || NUM_VOICES > 8) begin : g_bad_voices
    $error("sid_regbank: NUM_VOICES must be 1..8");
  end
  if (FB + FILTER_REGS > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("sid_regbank: ADDR_W too small for the register map");
  end
  if (DECAY_TICKS < 2) begin : g_bad_decay
    $error("sid_regbank: DECAY_TICKS must be at least 2");
  end

  logic                   wr, rd;
  int unsigned            addr_i;
  int unsigned            reg_off;
  logic [NUM_VOICES-1:0]  voice_hit;
  logic                   filt_hit, ro_hit;
  logic [7:0]             ro_val;
  logic [7:0]             latch_q;
  logic [NUM_VOICES-1:0]  gate_cur, gate_prev_q;

  voice_cfg_t [NUM_VOICES-1:0] voice_q;
  filter_cfg_t                 filt_q;

  assign wr = ~n_cs & ~rw;
  assign rd = ~n_cs & rw;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    addr_i    = 32'(addr);
    reg_off   = 0;
    voice_hit = '0;
    filt_hit  = 1'b0;
    ro_hit    = 1'b0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (addr_i >= VOICE_REGS * v && addr_i < VOICE_REGS * (v + 1)) begin
        voice_hit[v] = 1'b1;
        reg_off      = addr_i - VOICE_REGS * v;
      end
    end
    if (addr_i >= FB && addr_i < FB + FILTER_REGS) begin
      reg_off  = addr_i - FB;
      filt_hit = (reg_off < OFF_POTX);
      ro_hit   = (reg_off >= OFF_POTX);
    end
  end

  always_comb begin
    case (reg_off)
      OFF_POTX: ro_val = pot_x;
      OFF_POTY: ro_val = pot_y;
      OFF_OSC3: ro_val = osc_msb[NUM_VOICES-1];
      OFF_ENV3: ro_val = env_lvl[NUM_VOICES-1];
      default:  ro_val = 8'h00;
    endcase
  end

  // Only the last voice's oscillator/envelope are readable; the rest pass through unused.
  logic unused_inputs;
  assign unused_inputs = ^{osc_msb, env_lvl};

  always_ff @(posedge clk) begin
    if (reset) begin
      voice_q <= '0;
      filt_q  <= '0;
    end else if (wr) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (voice_hit[v]) begin
          case (reg_off)
            OFF_FREQ_LO: voice_q[v].freq[7:0]          <= data_in;
            OFF_FREQ_HI: voice_q[v].freq[15:8]         <= data_in;
            OFF_PW_LO:   voice_q[v].pw[7:0]            <= data_in;
            OFF_PW_HI:   voice_q[v].pw[11:8]           <= data_in[3:0];
            OFF_CTRL:    voice_q[v].control            <= data_in;
            OFF_AD:      {voice_q[v].atk, voice_q[v].dcy} <= data_in;
            OFF_SR:      {voice_q[v].stn, voice_q[v].rls} <= data_in;
            default:     ;
          endcase
        end
      end
      if (filt_hit) begin
        case (reg_off)
          OFF_FC_LO:    filt_q.fc[2:0]  <= data_in[2:0];
          OFF_FC_HI:    filt_q.fc[10:3] <= data_in;
          OFF_RES_FILT: {filt_q.res, filt_q.filt} <= data_in;
          OFF_MODE_VOL: {filt_q.off3, filt_q.hp, filt_q.bp, filt_q.lp, filt_q.vol} <= data_in;
          default:      ;
        endcase
      end
    end
  end

  always_comb begin
    gate_cur = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) gate_cur[v] = voice_q[v].control[CTRL_GATE];
  end

  // Reset clears both the gate and its history, so a set gate never yields gate_off on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_prev_q <= '0;
      gate_on     <= '0;
      gate_off    <= '0;
    end else begin
      gate_prev_q <= gate_cur;
      gate_on     <= gate_cur & ~gate_prev_q;
      gate_off    <= ~gate_cur & gate_prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= 8'h00;
      data_oe  <= 1'b0;
    end else begin
      data_oe <= rd;
      if (rd) data_out <= ro_hit ? ro_val : latch_q;
    end
  end

  sid_bus_latch #(
    .DECAY_TICKS (DECAY_TICKS)
  ) u_bus_latch (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .load      (wr | (rd & ro_hit)),
    .load_data (wr ? data_in : ro_val),
    .latch_q   (latch_q)
  );

  assign voice_cfg = voice_q;
  assign filt_cfg  = filt_q;

endmodule

// File: tb/tb_sid_regbank.sv
// Randomised and directed bench for sid_regbank against a register-image reference model.
module tb_sid_regbank;
  import sid_pkg::*;

  localparam int NV  = 3;
  localparam int DT  = 2048;
  localparam int MFB = 7 * NV;
  localparam int NV2 = 5;

  logic clk = 1'b0;
  logic reset = 1'b0, clk_en = 1'b0, n_cs = 1'b1, rw = 1'b1;
  logic [5:0] addr_w = '0;
  logic [7:0] data_in = '0, pot_x = '0, pot_y = '0;
  logic [NV-1:0][7:0]  osc_msb = '0, env_lvl = '0;
  logic [NV2-1:0][7:0] osc_msb2 = '0, env_lvl2 = '0;

  logic [7:0] data_out, data_out2;
  logic       data_oe, data_oe2;
  voice_cfg_t [NV-1:0]  voice_cfg;
  voice_cfg_t [NV2-1:0] voice_cfg2;
  filter_cfg_t filt_cfg, filt_cfg2;
  logic [NV-1:0]  gate_on, gate_off;
  logic [NV2-1:0] gate_on2, gate_off2;

  always #5 clk = ~clk;

  sid_regbank dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .addr(addr_w[4:0]), .data_in(data_in),
    .n_cs(n_cs), .rw(rw), .data_out(data_out), .data_oe(data_oe), .pot_x(pot_x),
    .pot_y(pot_y), .osc_msb(osc_msb), .env_lvl(env_lvl), .voice_cfg(voice_cfg),
    .filt_cfg(filt_cfg), .gate_on(gate_on), .gate_off(gate_off)
  );

  sid_regbank #(.NUM_VOICES(NV2), .ADDR_W(6)) dut2 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .addr(addr_w), .data_in(data_in),
    .n_cs(n_cs), .rw(rw), .data_out(data_out2), .data_oe(data_oe2), .pot_x(pot_x),
    .pot_y(pot_y), .osc_msb(osc_msb2), .env_lvl(env_lvl2), .voice_cfg(voice_cfg2),
    .filt_cfg(filt_cfg2), .gate_on(gate_on2), .gate_off(gate_off2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: raw byte image of the writable map plus bus latch and decay count.
  logic [7:0]    img [32];
  logic [7:0]    m_lat, m_dout;
  int            m_cnt;
  logic          m_oe;
  logic [NV-1:0] m_on, m_off, m_hist;

  task automatic model_step();
    int a;
    logic g, reload;
    logic [7:0] ro;
    a = int'(addr_w[4:0]);
    reload = 1'b0;
    if (reset) begin
      foreach (img[i]) img[i] = 8'h00;
      m_lat = 0; m_cnt = 0; m_dout = 0; m_oe = 0; m_on = 0; m_off = 0; m_hist = 0;
      return;
    end
    for (int v = 0; v < NV; v++) begin
      g = img[7*v + 4][0];
      m_on[v]   = g && !m_hist[v];
      m_off[v]  = !g && m_hist[v];
      m_hist[v] = g;
    end
    m_oe = !n_cs && rw;
    if (!n_cs && rw) begin
      if (a >= MFB + 4 && a <= MFB + 7) begin
        ro = (a == MFB + 4) ? pot_x : (a == MFB + 5) ? pot_y :
             (a == MFB + 6) ? osc_msb[NV-1] : env_lvl[NV-1];
        m_dout = ro; m_lat = ro; reload = 1'b1;
      end else begin
        m_dout = m_lat;
      end
    end else if (!n_cs && !rw) begin
      if (a < MFB + 4) img[a] = data_in;
      m_lat = data_in; reload = 1'b1;
    end
    if (reload) m_cnt = DT;
    else if (clk_en && m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_lat = 8'h00;
    end
  endtask

  function automatic voice_cfg_t exp_voice(input int v);
    voice_cfg_t e;
    int b;
    b = 7 * v;
    e.freq    = {img[b+1], img[b]};
    e.pw      = {img[b+3][3:0], img[b+2]};
    e.control = img[b+4];
    e.atk = img[b+5][7:4]; e.dcy = img[b+5][3:0];
    e.stn = img[b+6][7:4]; e.rls = img[b+6][3:0];
    return e;
  endfunction

  function automatic filter_cfg_t exp_filt();
    filter_cfg_t e;
    logic [7:0] mv;
    mv = img[MFB+3];
    e.fc   = {img[MFB+1], img[MFB][2:0]};
    e.res  = img[MFB+2][7:4];
    e.filt = img[MFB+2][3:0];
    e.off3 = mv[7]; e.hp = mv[6]; e.bp = mv[5]; e.lp = mv[4]; e.vol = mv[3:0];
    return e;
  endfunction

  task automatic compare();
    check("data_oe", data_oe, m_oe);
    check("data_out", data_out, m_dout);
    check("gate_on", gate_on, m_on);
    check("gate_off", gate_off, m_off);
    for (int v = 0; v < NV; v++) check($sformatf("voice_cfg[%0d]", v), voice_cfg[v], exp_voice(v));
    check("filt_cfg", filt_cfg, exp_filt());
  endtask

  task automatic cycle(input logic rst, input logic ce, input logic ncs, input logic r,
                       input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    reset = rst; clk_en = ce; n_cs = ncs; rw = r; addr_w = a; data_in = d;
    @(posedge clk);
    model_step();
    #1 compare();
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, a, d);
  endtask

  task automatic rd(input logic [5:0] a);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic idle(input logic ce);
    cycle(1'b0, ce, 1'b1, 1'b1, 6'h00, 8'h00);
  endtask

  int pulses;

  initial begin
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 8'hFF);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 6'h00, 8'h00);
    check("reset_data_out", data_out, 8'h00);

    // Field assembly
    wr(6'h00, 8'h34); wr(6'h01, 8'h12); wr(6'h03, 8'hFF);
    check("freq_1234", voice_cfg[0].freq, 16'h1234);
    check("pw_hi_nibble", voice_cfg[0].pw[11:8], 4'hF);

    // Gate edges on voice 2
    wr(6'h12, 8'h11);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin idle(1'b0); pulses += int'(gate_on[2]); end
    check("gate_on_once", pulses, 1);
    wr(6'h12, 8'h10);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin idle(1'b0); pulses += int'(gate_off[2]); end
    check("gate_off_once", pulses, 1);
    wr(6'h12, 8'h10);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin idle(1'b0); pulses += int'(gate_on[2]) + int'(gate_off[2]); end
    check("gate_repeat_none", pulses, 0);

    // Bus latch decay boundary
    wr(6'h00, 8'hA5);
    rd(6'h00);
    check("latch_read_a5", data_out, 8'hA5);
    for (int i = 0; i < DT - 1; i++) idle(1'b1);
    rd(6'h00);
    check("latch_tick_2047", data_out, 8'hA5);
    idle(1'b1);
    rd(6'h00);
    check("latch_tick_2048", data_out, 8'h00);

    // Read-only register loads the latch
    env_lvl[2] = 8'h7F;
    rd(6'h1C);
    check("env3_read", data_out, 8'h7F);
    check("env3_oe", data_oe, 1'b1);
    idle(1'b0);
    check("oe_drops", data_oe, 1'b0);
    rd(6'h04);
    check("latch_after_env3", data_out, 8'h7F);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      pot_x = 8'($urandom); pot_y = 8'($urandom);
      osc_msb = 24'($urandom); env_lvl = 24'($urandom);
      cycle(($urandom_range(0, 199) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
            1'($urandom), 6'($urandom_range(0, 31)), 8'($urandom));
    end

    // Reset during a write burst with the gate set
    wr(6'h04, 8'h01); wr(6'h04, 8'h01); wr(6'h04, 8'h01);
    idle(1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'h04, 8'h01);
    check("rst_voice0", voice_cfg[0], 52'h0);
    check("rst_gate_off", gate_off, 3'b000);
    check("rst_oe", data_oe, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(1'b0);
      check("post_rst_gate_off", gate_off, 3'b000);
    end

    // Five-voice instance with six address bits
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 6'h00, 8'h00);
    wr(6'h26, 8'h80);
    check("d2_off3", filt_cfg2.off3, 1'b1);
    check("d2_vol", filt_cfg2.vol, 4'h0);
    wr(6'h1C, 8'h77);
    check("d2_v4_freq", voice_cfg2[4].freq, 16'h0077);
    osc_msb2[4] = 8'h5A;
    rd(6'h29);
    check("d2_osc3", data_out2, 8'h5A);
    env_lvl2[4] = 8'hC3;
    rd(6'h2A);
    check("d2_env3", data_out2, 8'hC3);
    rd(6'h00);
    check("d2_latch", data_out2, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
